bshift_rx_ctrl: RTL and testbench

// - Serial frame receiver controller: detects start bit on i_rx, generates mid-bit sample strobes,

---
 rtl/bshift_rx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bshift_rx_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bshift_rx_ctrl.sv
// bshift_rx_ctrl: serial frame receiver controller.
// Detects a start bit on i_rx, samples each bit at mid-bit, shifts DATA_BITS
// bits MSB-first into a shift register, checks the stop bit and hands the word
// to the consumer through a one-deep valid/ready holding register.
// Optional build macro RX_PARITY_EN adds an even-parity bit after the data
// bits and the o_parity_err output.
module bshift_rx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 i_sclr,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
`ifdef RX_PARITY_EN
    output logic                 o_overrun,
    output logic                 o_parity_err
`else
    output logic                 o_overrun
`endif
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [BIT_W-1:0]       bit_reg, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   shift_ins;
    logic                   stop_sample;
    logic                   word_done;

    logic [DATA_BITS-1:0]   data_reg;
    logic                   valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_reg;

`ifdef RX_PARITY_EN
    logic                   par_reg, par_next;
    logic                   parity_err_reg;
`endif

    // Left-shift with the newly sampled line value inserted at the LSB,
    // so the first-received bit ends up in the MSB.
    assign shift_ins[0] = i_rx;
    generate
        for (genvar gi = 1; gi < DATA_BITS; gi++) begin : g_shift
            assign shift_ins[gi] = shift_reg[gi-1];
        end
    endgenerate

    // State, baud counter, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
`ifdef RX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
`ifdef RX_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    // Next-state logic; the baud counter restarts at zero on every state entry
    // and its terminal count is the sample point of the current bit.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_ONE;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        stop_sample = 1'b0;
`ifdef RX_PARITY_EN
        par_next    = par_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!i_rx) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = i_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = shift_ins;
                    if (bit_reg == DATA_LAST) begin
`ifdef RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BIT_ONE;
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    par_next   = i_rx;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next    = '0;
                    stop_sample = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign word_done = stop_sample & i_rx;

    // Output holding register: a finished word loads if the slot is free or is
    // being emptied this cycle; otherwise the new word is dropped as an overrun.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg <= stop_sample & ~i_rx;
            overrun_reg   <= word_done & valid_reg & ~i_ready;
`ifdef RX_PARITY_EN
            parity_err_reg <= word_done & (^{shift_reg, par_reg});
`endif
            if (word_done && (!valid_reg || i_ready)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
            end else if (valid_reg && i_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign o_data      = data_reg;
    assign o_valid     = valid_reg;
    assign o_busy      = (state_reg != S_IDLE);
    assign o_frame_err = frame_err_reg;
    assign o_overrun   = overrun_reg;
`ifdef RX_PARITY_EN
    assign o_parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_bshift_rx_ctrl.sv
// Directed testbench for bshift_rx_ctrl (DATA_BITS=8, CLKS_PER_BIT=16).
// Frames are driven cycle by cycle relative to t0, the edge that first sees
// the start bit; outputs are recorded 1 time unit after each edge.
module tb_bshift_rx_ctrl;

    localparam int NMAX = 200;

    logic       clk;
    logic       i_sclr;
    logic       i_rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;
`ifdef RX_PARITY_EN
    logic       o_parity_err;
`endif

    int checks;
    int failures;

    logic [7:0] obs_data [0:NMAX-1];
    logic       obs_valid[0:NMAX-1];
    logic       obs_busy [0:NMAX-1];
    logic       obs_ferr [0:NMAX-1];
    logic       obs_ovr  [0:NMAX-1];
    logic       obs_perr [0:NMAX-1];

    bshift_rx_ctrl #(
        .DATA_BITS   (8),
        .CLKS_PER_BIT(16)
    ) dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_rx        (i_rx),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
`ifdef RX_PARITY_EN
        .o_overrun   (o_overrun),
        .o_parity_err(o_parity_err)
`else
        .o_overrun   (o_overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level for cycle k of a frame: start, 8 data bits MSB first,
    // optional parity bit, stop bit, then idle high.
    function automatic logic line_bit(input logic [7:0] d, input logic stop_b,
                                      input logic par_b, input logic use_par, input int k);
        int b;
        int stop_idx;
        b = k / 16;
        stop_idx = use_par ? 10 : 9;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[8-b];
        if (use_par && b == 9) return par_b;
        if (b == stop_idx) return stop_b;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        i_rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                               input logic use_par, input logic ready_base, input int ready_k,
                               input int sclr_k, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            i_rx    = line_bit(d, stop_b, par_b, use_par, k);
            i_ready = (k == ready_k) ? 1'b1 : ready_base;
            i_sclr  = (k == sclr_k);
            @(posedge clk);
            #1;
            obs_data[k]  = o_data;
            obs_valid[k] = o_valid;
            obs_busy[k]  = o_busy;
            obs_ferr[k]  = o_frame_err;
            obs_ovr[k]   = o_overrun;
`ifdef RX_PARITY_EN
            obs_perr[k]  = o_parity_err;
`else
            obs_perr[k]  = 1'b0;
`endif
        end
        i_rx    = 1'b1;
        i_sclr  = 1'b0;
        i_ready = ready_base;
        $display("frame data=%02h stop=%0b par=%0b/%0b ready=%0b -> o_valid@152=%0b o_data@152=%02h",
                 d, stop_b, use_par, par_b, ready_base, obs_valid[use_par ? 168 : 152],
                 obs_data[use_par ? 168 : 152]);
    endtask

    function automatic int count_pulses(input int sel, input int from, input int to);
        int n;
        n = 0;
        for (int k = from; k < to; k++) begin
            case (sel)
                0: if (obs_ferr[k] === 1'b1) n++;
                1: if (obs_ovr[k] === 1'b1) n++;
                2: if (obs_perr[k] === 1'b1) n++;
                3: if (obs_valid[k] === 1'b1) n++;
                default: if (obs_busy[k] === 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    task automatic test_reset();
        int n;
        i_sclr = 1'b1; i_rx = 1'b1; i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        i_sclr = 1'b0;
        n = {31'd0, o_valid} + {31'd0, o_busy} + {31'd0, o_frame_err} + {31'd0, o_overrun};
        checks++;
        if (n != 0 || o_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: valid=%0b busy=%0b ferr=%0b ovr=%0b data=%02h required all 0",
                     o_valid, o_busy, o_frame_err, o_overrun, o_data);
        end
        $display("reset applied: data=%02h valid=%0b busy=%0b", o_data, o_valid, o_busy);
        idle(4);
    endtask

    task automatic test_basic_frame();
        int n;
        drive_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 170);
        checks++;
        if (obs_busy[0] !== 1'b1 || obs_busy[151] !== 1'b1 || obs_busy[152] !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: busy@0=%0b @151=%0b @152=%0b required 1 1 0",
                     obs_busy[0], obs_busy[151], obs_busy[152]);
        end
        checks++;
        if (obs_valid[151] !== 1'b0 || obs_valid[152] !== 1'b1 || obs_valid[153] !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid: valid@151=%0b @152=%0b @153=%0b required 0 1 0",
                     obs_valid[151], obs_valid[152], obs_valid[153]);
        end
        checks++;
        if (obs_data[152] !== 8'hA5) begin
            failures++;
            $display("FAIL basic_data: o_data=%02h required a5", obs_data[152]);
        end
        n = count_pulses(0, 0, 170) + count_pulses(1, 0, 170) + count_pulses(2, 0, 170);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL basic_flags: flag pulses=%0d required 0", n);
        end
        idle(4);
    endtask

    task automatic test_glitch();
        logic busy_ok;
        int vcount;
        busy_ok = 1'b1;
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            i_rx = (k < 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (k < 8 && o_busy !== 1'b1) busy_ok = 1'b0;
            if (k >= 8 && o_busy !== 1'b0) busy_ok = 1'b0;
            if (o_valid !== 1'b0 || o_frame_err !== 1'b0) vcount++;
        end
        $display("glitch: 3-cycle low start, busy profile ok=%0b", busy_ok);
        checks++;
        if (busy_ok !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy: busy profile wrong, required 1 for k<8 and 0 from k=8");
        end
        checks++;
        if (vcount != 0) begin
            failures++;
            $display("FAIL glitch_flags: cycles with valid/err=%0d required 0", vcount);
        end
        idle(4);
    endtask

    task automatic test_frame_err();
        int n;
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 175);
        checks++;
        if (obs_ferr[151] !== 1'b0 || obs_ferr[152] !== 1'b1 || obs_ferr[153] !== 1'b0) begin
            failures++;
            $display("FAIL ferr_pulse: ferr@151=%0b @152=%0b @153=%0b required 0 1 0",
                     obs_ferr[151], obs_ferr[152], obs_ferr[153]);
        end
        n = count_pulses(0, 0, 175);
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL ferr_count: pulses=%0d required 1", n);
        end
        n = count_pulses(3, 0, 175);
        checks++;
        if (n != 0 || obs_data[174] !== 8'hA5) begin
            failures++;
            $display("FAIL ferr_word: valid cycles=%0d data=%02h required 0 and a5", n, obs_data[174]);
        end
        idle(4);
    endtask

    task automatic test_overrun();
        int n;
        drive_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 170);
        checks++;
        if (obs_valid[152] !== 1'b1 || obs_data[152] !== 8'h11 || obs_ovr[152] !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first: valid=%0b data=%02h ovr=%0b required 1 11 0",
                     obs_valid[152], obs_data[152], obs_ovr[152]);
        end
        drive_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 170);
        checks++;
        if (obs_ovr[152] !== 1'b1 || obs_ovr[153] !== 1'b0) begin
            failures++;
            $display("FAIL ovr_pulse: ovr@152=%0b @153=%0b required 1 0", obs_ovr[152], obs_ovr[153]);
        end
        n = count_pulses(1, 0, 170);
        checks++;
        if (n != 1 || obs_data[169] !== 8'h11 || obs_valid[169] !== 1'b1) begin
            failures++;
            $display("FAIL ovr_hold: pulses=%0d data=%02h valid=%0b required 1 11 1",
                     n, obs_data[169], obs_valid[169]);
        end
    endtask

    task automatic test_back_to_back();
        drive_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 152, -1, 170);
        checks++;
        if (obs_data[151] !== 8'h11 || obs_data[152] !== 8'h22 || obs_data[153] !== 8'h22) begin
            failures++;
            $display("FAIL b2b_data: data@151=%02h @152=%02h @153=%02h required 11 22 22",
                     obs_data[151], obs_data[152], obs_data[153]);
        end
        checks++;
        if (obs_valid[152] !== 1'b1 || obs_valid[153] !== 1'b1 || count_pulses(1, 0, 170) != 0) begin
            failures++;
            $display("FAIL b2b_valid: valid@152=%0b @153=%0b ovr=%0d required 1 1 0",
                     obs_valid[152], obs_valid[153], count_pulses(1, 0, 170));
        end
    endtask

    task automatic test_mid_reset();
        int n;
        drive_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, -1, 88, 170);
        checks++;
        if (obs_busy[87] !== 1'b1 || obs_valid[87] !== 1'b1) begin
            failures++;
            $display("FAIL mrst_before: busy=%0b valid=%0b required 1 1", obs_busy[87], obs_valid[87]);
        end
        checks++;
        if (obs_busy[88] !== 1'b0 || obs_valid[88] !== 1'b0 || obs_data[88] !== 8'h00) begin
            failures++;
            $display("FAIL mrst_after: busy=%0b valid=%0b data=%02h required 0 0 00",
                     obs_busy[88], obs_valid[88], obs_data[88]);
        end
        n = count_pulses(3, 88, 170) + count_pulses(4, 88, 170) + count_pulses(0, 88, 170);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL mrst_quiet: valid/busy/err cycles=%0d required 0", n);
        end
        idle(4);
        drive_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 170);
        checks++;
        if (obs_valid[152] !== 1'b1 || obs_data[152] !== 8'h81 || obs_valid[153] !== 1'b0) begin
            failures++;
            $display("FAIL mrst_next: valid=%0b data=%02h valid@153=%0b required 1 81 0",
                     obs_valid[152], obs_data[152], obs_valid[153]);
        end
        idle(4);
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        drive_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, 185);
        checks++;
        if (obs_valid[168] !== 1'b1 || obs_data[168] !== 8'h07 || count_pulses(2, 0, 185) != 0) begin
            failures++;
            $display("FAIL par_good: valid=%0b data=%02h perr=%0d required 1 07 0",
                     obs_valid[168], obs_data[168], count_pulses(2, 0, 185));
        end
        idle(4);
        drive_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 185);
        checks++;
        if (obs_perr[168] !== 1'b1 || obs_data[168] !== 8'h07 || count_pulses(2, 0, 185) != 1) begin
            failures++;
            $display("FAIL par_bad: perr@168=%0b data=%02h pulses=%0d required 1 07 1",
                     obs_perr[168], obs_data[168], count_pulses(2, 0, 185));
        end
        idle(4);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        i_sclr   = 1'b1;
        i_rx     = 1'b1;
        i_ready  = 1'b1;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
